// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480@60 timing constants, counter width and shared pixel-position type.
// Also holds the total-period helper used to size the raster counters.
package vga_pkg;

    localparam int CNT_W     = 10;
    localparam int MAX_TOTAL = 1 << CNT_W;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    typedef struct packed {
        logic             de;
        logic [CNT_W-1:0] x;
        logic [CNT_W-1:0] y;
    } vga_pix_t;

    function automatic int vga_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_wrap_cnt.sv
// vga_wrap_cnt: modulo-(MAX+1) counter, reset loads MAX so the first enabled edge yields 0.
// Latency: cnt updates on the enabled edge; tc is combinational (cnt == MAX).
// Backpressure: en=0 holds the count.
module vga_wrap_cnt #(
    parameter int MAX = 799,
    parameter int W   = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         tc
);

    localparam logic [W-1:0] LAST = W'(MAX);

    assign tc = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= LAST;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing (hsync/vsync/de/x/y/sof/eol); VGA_PREFETCH_EN adds pix_req/req_x/req_y one enabled cycle ahead.
// Latency: outputs are registered and decode the counter values loaded on the same edge.
// Backpressure: en=0 freezes counters and outputs, with sof/eol forced low.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             sof,
    output logic             eol
`ifdef VGA_PREFETCH_EN
    ,
    output logic             pix_req,
    output logic [CNT_W-1:0] req_x,
    output logic [CNT_W-1:0] req_y
`endif
);

    localparam int H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_timing
        $fatal(1, "vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end

    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] v;
    logic             h_tc;
    logic             v_tc;
    logic [CNT_W-1:0] h_nxt;
    logic [CNT_W-1:0] v_nxt;
    vga_pix_t         pix_nxt;
    logic             hs_act;
    logic             vs_act;
    logic             eol_nxt;

    vga_wrap_cnt #(.MAX(H_TOTAL - 1), .W(CNT_W)) u_h_cnt (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .cnt (h),
        .tc  (h_tc)
    );

    vga_wrap_cnt #(.MAX(V_TOTAL - 1), .W(CNT_W)) u_v_cnt (
        .clk (clk),
        .rst (rst),
        .en  (en & h_tc),
        .cnt (v),
        .tc  (v_tc)
    );

    function automatic vga_pix_t pix_dec(input logic [CNT_W-1:0] hc, input logic [CNT_W-1:0] vc);
        vga_pix_t p;
        p.de = (int'(hc) < H_ACTIVE) && (int'(vc) < V_ACTIVE);
        p.x  = p.de ? hc : '0;
        p.y  = p.de ? vc : '0;
        return p;
    endfunction

    // Decode the position the counters move to on this enabled edge, so outputs carry no extra latency.
    always_comb begin
        h_nxt   = h_tc ? '0 : h + CNT_W'(1);
        v_nxt   = h_tc ? (v_tc ? '0 : v + CNT_W'(1)) : v;
        pix_nxt = pix_dec(h_nxt, v_nxt);
        hs_act  = (int'(h_nxt) >= H_ACTIVE + H_FP) && (int'(h_nxt) < H_ACTIVE + H_FP + H_SYNC);
        vs_act  = (int'(v_nxt) >= V_ACTIVE + V_FP) && (int'(v_nxt) < V_ACTIVE + V_FP + V_SYNC);
        eol_nxt = (int'(h_nxt) == H_ACTIVE - 1) && (int'(v_nxt) < V_ACTIVE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            de    <= 1'b0;
            x     <= '0;
            y     <= '0;
            sof   <= 1'b0;
            eol   <= 1'b0;
            hsync <= ~SYNC_POL;
            vsync <= ~SYNC_POL;
        end else if (en) begin
            de    <= pix_nxt.de;
            x     <= pix_nxt.x;
            y     <= pix_nxt.y;
            sof   <= h_tc & v_tc;
            eol   <= eol_nxt;
            hsync <= hs_act ? SYNC_POL : ~SYNC_POL;
            vsync <= vs_act ? SYNC_POL : ~SYNC_POL;
        end else begin
            sof <= 1'b0;
            eol <= 1'b0;
        end
    end

`ifdef VGA_PREFETCH_EN
    logic [CNT_W-1:0] h_nn;
    logic [CNT_W-1:0] v_nn;
    vga_pix_t         pix_nn;

    // One position beyond the next one: the request leads de/x/y by exactly one enabled cycle.
    always_comb begin
        h_nn   = (int'(h_nxt) == H_TOTAL - 1) ? '0 : h_nxt + CNT_W'(1);
        v_nn   = v_nxt;
        if (int'(h_nxt) == H_TOTAL - 1) begin
            v_nn = (int'(v_nxt) == V_TOTAL - 1) ? '0 : v_nxt + CNT_W'(1);
        end
        pix_nn = pix_dec(h_nn, v_nn);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_req <= 1'b0;
            req_x   <= '0;
            req_y   <= '0;
        end else if (en) begin
            pix_req <= pix_nn.de;
            req_x   <= pix_nn.x;
            req_y   <= pix_nn.y;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two reduced-timing instances (both sync polarities) and one default 640x480 instance,
// each checked cycle by cycle against a behavioural raster model through per-instance expectation queues.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;

    always #5 clk = ~clk;

    logic       hsync_s, vsync_s, de_s, sof_s, eol_s;
    logic [9:0] x_s, y_s;
    logic       hsync_p, vsync_p, de_p, sof_p, eol_p;
    logic [9:0] x_p, y_p;
    logic       hsync_d, vsync_d, de_d, sof_d, eol_d;
    logic [9:0] x_d, y_d;
`ifdef VGA_PREFETCH_EN
    logic       pr_s, pr_p, pr_d;
    logic [9:0] rx_s, ry_s, rx_p, ry_p, rx_d, ry_d;
`endif

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(5), .V_FP(2), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0)
    ) dut_s (
        .clk(clk), .rst(rst), .en(en), .hsync(hsync_s), .vsync(vsync_s), .de(de_s),
        .x(x_s), .y(y_s), .sof(sof_s), .eol(eol_s)
`ifdef VGA_PREFETCH_EN
        , .pix_req(pr_s), .req_x(rx_s), .req_y(ry_s)
`endif
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(5), .V_FP(2), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1)
    ) dut_p (
        .clk(clk), .rst(rst), .en(en), .hsync(hsync_p), .vsync(vsync_p), .de(de_p),
        .x(x_p), .y(y_p), .sof(sof_p), .eol(eol_p)
`ifdef VGA_PREFETCH_EN
        , .pix_req(pr_p), .req_x(rx_p), .req_y(ry_p)
`endif
    );

    vga_timing_gen dut_d (
        .clk(clk), .rst(rst), .en(en), .hsync(hsync_d), .vsync(vsync_d), .de(de_d),
        .x(x_d), .y(y_d), .sof(sof_d), .eol(eol_d)
`ifdef VGA_PREFETCH_EN
        , .pix_req(pr_d), .req_x(rx_d), .req_y(ry_d)
`endif
    );

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb;
        bit pol;
    } tim_t;

    typedef struct {
        logic       de;
        logic [9:0] x, y;
        logic       hs, vs, sof, eol, pr;
        logic [9:0] rx, ry;
    } exp_t;

    tim_t tims[3];
    int   mh[3];
    int   mv[3];
    exp_t last[3];
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int sof_cnt = 0;
    int last_sof = -1;
    int sof_per = 0;

    function automatic exp_t rst_exp(input tim_t t);
        exp_t e;
        e = '{default: '0};
        e.hs = ~t.pol;
        e.vs = ~t.pol;
        return e;
    endfunction

    function automatic exp_t decode(input tim_t t, input int h, input int v);
        exp_t e;
        int ht, vt, nh, nv;
        ht = t.ha + t.hf + t.hs + t.hb;
        vt = t.va + t.vf + t.vs + t.vb;
        e.de  = (h < t.ha) && (v < t.va);
        e.x   = e.de ? 10'(h) : 10'd0;
        e.y   = e.de ? 10'(v) : 10'd0;
        e.hs  = ((h >= t.ha + t.hf) && (h < t.ha + t.hf + t.hs)) ? t.pol : ~t.pol;
        e.vs  = ((v >= t.va + t.vf) && (v < t.va + t.vf + t.vs)) ? t.pol : ~t.pol;
        e.sof = (h == 0) && (v == 0);
        e.eol = (h == t.ha - 1) && (v < t.va);
        nh = (h + 1) % ht;
        nv = (h == ht - 1) ? (v + 1) % vt : v;
        e.pr  = (nh < t.ha) && (nv < t.va);
        e.rx  = e.pr ? 10'(nh) : 10'd0;
        e.ry  = e.pr ? 10'(nv) : 10'd0;
        return e;
    endfunction

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic cmp_inst(input string n, input exp_t o, input exp_t e);
        cmp({n, ".de"}, 32'(o.de), 32'(e.de));
        cmp({n, ".x"}, 32'(o.x), 32'(e.x));
        cmp({n, ".y"}, 32'(o.y), 32'(e.y));
        cmp({n, ".hsync"}, 32'(o.hs), 32'(e.hs));
        cmp({n, ".vsync"}, 32'(o.vs), 32'(e.vs));
        cmp({n, ".sof"}, 32'(o.sof), 32'(e.sof));
        cmp({n, ".eol"}, 32'(o.eol), 32'(e.eol));
`ifdef VGA_PREFETCH_EN
        cmp({n, ".pix_req"}, 32'(o.pr), 32'(e.pr));
        cmp({n, ".req_x"}, 32'(o.rx), 32'(e.rx));
        cmp({n, ".req_y"}, 32'(o.ry), 32'(e.ry));
`endif
    endtask

    // Drive one cycle: push model expectations, clock, then pop and compare each instance.
    task automatic step(input logic r, input logic e);
        exp_t ob;
        rst = r;
        en  = e;
        for (int i = 0; i < 3; i++) begin
            if (r) begin
                mh[i]   = tims[i].ha + tims[i].hf + tims[i].hs + tims[i].hb - 1;
                mv[i]   = tims[i].va + tims[i].vf + tims[i].vs + tims[i].vb - 1;
                last[i] = rst_exp(tims[i]);
            end else if (e) begin
                if (mh[i] == tims[i].ha + tims[i].hf + tims[i].hs + tims[i].hb - 1) begin
                    mh[i] = 0;
                    mv[i] = (mv[i] + 1) % (tims[i].va + tims[i].vf + tims[i].vs + tims[i].vb);
                end else begin
                    mh[i] = mh[i] + 1;
                end
                last[i] = decode(tims[i], mh[i], mv[i]);
            end else begin
                last[i].sof = 1'b0;
                last[i].eol = 1'b0;
            end
            case (i)
                0:       q0.push_back(last[i]);
                1:       q1.push_back(last[i]);
                default: q2.push_back(last[i]);
            endcase
        end
        @(posedge clk);
        #1;
        ob = '{default: '0};
        ob.de = de_s; ob.x = x_s; ob.y = y_s; ob.hs = hsync_s; ob.vs = vsync_s; ob.sof = sof_s; ob.eol = eol_s;
`ifdef VGA_PREFETCH_EN
        ob.pr = pr_s; ob.rx = rx_s; ob.ry = ry_s;
`endif
        cmp_inst("small", ob, q0.pop_front());
        ob.de = de_p; ob.x = x_p; ob.y = y_p; ob.hs = hsync_p; ob.vs = vsync_p; ob.sof = sof_p; ob.eol = eol_p;
`ifdef VGA_PREFETCH_EN
        ob.pr = pr_p; ob.rx = rx_p; ob.ry = ry_p;
`endif
        cmp_inst("pol1", ob, q1.pop_front());
        ob.de = de_d; ob.x = x_d; ob.y = y_d; ob.hs = hsync_d; ob.vs = vsync_d; ob.sof = sof_d; ob.eol = eol_d;
`ifdef VGA_PREFETCH_EN
        ob.pr = pr_d; ob.rx = rx_d; ob.ry = ry_d;
`endif
        cmp_inst("dflt", ob, q2.pop_front());
        if (sof_s === 1'b1) begin
            sof_cnt++;
            if (last_sof >= 0 && sof_per > 0) cmp("sof_period", 32'(cyc - last_sof), 32'(sof_per));
            last_sof = cyc;
        end
        cyc++;
    endtask

    initial begin
        int de_cnt, hs_cnt, hs_first;
        tims[0] = '{8, 2, 3, 3, 5, 2, 2, 1, 1'b0};
        tims[1] = '{8, 2, 3, 3, 5, 2, 2, 1, 1'b1};
        tims[2] = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0};

        // Reset, with en high for part of it to show rst wins.
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);

        // Continuous enable: small frame is 16x10 = 160 cycles; default line is 800 cycles.
        sof_cnt = 0; last_sof = -1; sof_per = 160;
        de_cnt = 0; hs_cnt = 0; hs_first = -1;
        for (int k = 0; k < 1700; k++) begin
            step(1'b0, 1'b1);
            if (k < 800) begin
                if (de_d === 1'b1) de_cnt++;
                if (hsync_d === 1'b0) begin
                    hs_cnt++;
                    if (hs_first < 0) hs_first = k;
                end
            end
            if (k == 799) begin
                cmp("dflt_de_per_line", 32'(de_cnt), 32'd640);
                cmp("dflt_hsync_width", 32'(hs_cnt), 32'd96);
                cmp("dflt_hsync_start", 32'(hs_first), 32'd656);
            end
        end
        cmp("sof_count_cont", 32'(sof_cnt), 32'd11);

        // en toggled every cycle: frame period doubles to 320 cycles.
        sof_cnt = 0; last_sof = -1; sof_per = 320;
        for (int i = 0; i < 700; i++) begin
            step(1'b0, (i % 2) == 0);
        end
        cmp("sof_count_toggle", 32'(sof_cnt), 32'd2);

        // Mid-frame reset on the small raster at h=5, v=3.
        sof_per = 0;
        for (int i = 0; i < 200 && !(mh[0] == 5 && mv[0] == 3); i++) begin
            step(1'b0, 1'b1);
        end
        cmp("reach_mid_frame", 32'(mh[0] == 5 && mv[0] == 3), 32'd1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        cmp("sof_after_rst_small", 32'(sof_s), 32'd1);
        cmp("sof_after_rst_dflt", 32'(sof_d), 32'd1);
        for (int i = 0; i < 40; i++) begin
            step(1'b0, (i % 3) != 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
